// File: rtl/fc_pkg.sv
// fc_pkg: shared state encoding and signed range helpers for the FC accumulator
package fc_pkg;
   localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2;
   function automatic longint smax(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction
   function automatic longint smin(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction
endpackage

// File: rtl/fc_sat_adder.sv
// fc_sat_adder: combinational signed add of a sign-extended product into a clamped accumulator
module fc_sat_adder import fc_pkg::*; #(
   parameter int ACC_W = 16,
   parameter int PW = 10
) (
   input  logic signed [ACC_W-1:0] a,
   input  logic signed [PW-1:0]    b,
   output logic signed [ACC_W-1:0] sum,
   output logic                    satHit
);
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(smax(ACC_W));
   localparam logic signed [ACC_W-1:0] MINV = ACC_W'(smin(ACC_W));
   logic [ACC_W:0] wide;
   always_comb begin
      wide = {a[ACC_W-1], a} + {{(ACC_W + 1 - PW){b[PW-1]}}, b};
      // the two top bits disagree only when the true sum left the ACC_W range
      satHit = wide[ACC_W] != wide[ACC_W-1];
      sum = !satHit ? wide[ACC_W-1:0] : wide[ACC_W] ? MINV : MAXV;
   end
endmodule

// File: rtl/fc_accumulator.sv
// fc_accumulator: counts a programmed number of products into a saturating sum and hands it off
module fc_accumulator import fc_pkg::*; #(
   parameter int N = 5,
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [CNT_W-1:0]        numInputs,
   input  logic                    prodValid,
   input  logic signed [2*N-1:0]   mulResult,
   output logic                    prodReady,
   output logic signed [ACC_W-1:0] accResult,
   output logic                    accValid,
   input  logic                    outReady,
   output logic                    accSat,
   output logic                    busy
);
   logic [1:0] state;
   logic [CNT_W-1:0] count, numLatched;
   logic signed [ACC_W-1:0] sum;
   logic satHit;
   fc_sat_adder #(.ACC_W(ACC_W), .PW(2 * N)) u_add (.a(accResult), .b(mulResult), .sum, .satHit);
   assign prodReady = state == ACCUM;
   assign accValid = state == DONE;
   assign busy = state != IDLE;
   // accResult doubles as the accumulator register, so it is registered by construction
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         accResult <= '0;
         count <= '0;
         numLatched <= '0;
         accSat <= 1'b0;
      end else
         case (state)
            IDLE: if (start) begin
               numLatched <= numInputs;
               accResult <= '0;
               count <= '0;
               accSat <= 1'b0;
               state <= numInputs != '0 ? ACCUM : DONE;
            end
            ACCUM: if (prodValid) begin
               accResult <= sum;
               accSat <= accSat | satHit;
               count <= count + 1'b1;
               if (count == numLatched - 1'b1) state <= DONE;
            end
            DONE: if (outReady) state <= IDLE;
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_fc_accumulator.sv
// tb_fc_accumulator: random and directed neurons on 16- and 12-bit accumulators against a saturating-sum model
module tb_fc_accumulator;
   logic clk = 0, rst_n = 0, start = 0, prodValid = 0, outReady = 0;
   logic [7:0] numInputs = '0;
   logic signed [9:0] mulResult = '0;
   logic pr16, v16, s16, b16, pr12, v12, s12, b12;
   logic signed [15:0] r16;
   logic signed [11:0] r12;
   logic signed [9:0] prods [0:255];
   int vecs = 0, errs = 0;

   fc_accumulator #(.N(5), .ACC_W(16), .CNT_W(8)) dut16 (.clk, .rst_n, .start, .numInputs, .prodValid,
      .mulResult, .prodReady(pr16), .accResult(r16), .accValid(v16), .outReady, .accSat(s16), .busy(b16));
   fc_accumulator #(.N(5), .ACC_W(12), .CNT_W(8)) dut12 (.clk, .rst_n, .start, .numInputs, .prodValid,
      .mulResult, .prodReady(pr12), .accResult(r12), .accValid(v12), .outReady, .accSat(s12), .busy(b12));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // per-beat clamped running sum of prods[0..n-1] at width w
   task automatic model(input int w, input int n, output longint s, output longint f);
      longint mx, mn;
      mx = (longint'(1) << (w - 1)) - 1;
      mn = -mx - 1;
      s = 0;
      f = 0;
      for (int i = 0; i < n; i++) begin
         s += longint'(prods[i]);
         if (s > mx) begin s = mx; f = 1; end
         else if (s < mn) begin s = mn; f = 1; end
      end
   endtask

   task automatic neuron(input int n, input int gap, input int hold, input bit b2b);
      longint e16, f16, e12, f12;
      model(16, n, e16, f16);
      model(12, n, e12, f12);
      chk("idle.busy", {b16, b12}, 0);
      start = 1;
      numInputs = 8'(n);
      step;
      start = 0;
      for (int i = 0; i < n; i++) begin
         int g;
         g = gap < 0 ? int'($urandom_range(0, 3)) : gap;
         for (int k = 0; k < g; k++) begin
            chk("stall.ready", {pr16, pr12}, 3);
            step;
         end
         prodValid = 1;
         mulResult = prods[i];
         chk("beat.ready", {pr16, pr12}, 3);
         step;
         prodValid = 0;
         mulResult = 10'($urandom);
      end
      chk("done.ready", {pr16, pr12}, 0);
      for (int h = 0; h <= hold; h++) begin
         chk("done.valid", {v16, v12}, 3);
         chk("res16", r16, e16);
         chk("res12", r12, e12);
         chk("sat16", s16, f16);
         chk("sat12", s12, f12);
         if (h < hold) step;
      end
      outReady = 1;
      start = b2b;
      step;
      outReady = 0;
      start = 0;
      chk("hs.valid", {v16, v12}, 0);
      chk("hs.busy", {b16, b12}, 0);
      if (b2b) begin
         step;
         chk("b2b.busy", {b16, b12}, 0);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".r16"}, r16, 0);
      chk({tag, ".r12"}, r12, 0);
      chk({tag, ".flags"}, {pr16, v16, s16, b16, pr12, v12, s12, b12}, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      #12;
      chk_zero("reset");
      rst_n = 1;
      step;
      chk_zero("post_reset");
      prods[0] = 15; prods[1] = -16; prods[2] = 100; prods[3] = -240;
      neuron(4, 0, 0, 0);
      prods[0] = 10; prods[1] = 20; prods[2] = 30;
      neuron(3, 2, 5, 0);
      for (int i = 0; i < 8; i++) prods[i] = 256;
      neuron(8, 0, 0, 0);
      prods[0] = -240; prods[1] = -240;
      neuron(2, 0, 0, 0);
      neuron(0, 0, 1, 0);
      for (int i = 0; i < 5; i++) prods[i] = 10'($urandom);
      start = 1;
      numInputs = 8'd5;
      step;
      start = 0;
      for (int i = 0; i < 2; i++) begin
         prodValid = 1;
         mulResult = prods[i];
         step;
      end
      prodValid = 0;
      #3 rst_n = 0;
      #1 chk_zero("async_reset");
      #2 rst_n = 1;
      step;
      chk_zero("after_reset");
      prods[0] = 1; prods[1] = 2; prods[2] = 3;
      neuron(3, 0, 0, 1);
      prods[0] = 7; prods[1] = -9;
      neuron(2, 1, 0, 0);
      for (int t = 0; t < 25; t++) begin
         int n;
         n = $urandom_range(0, 4) == 0 ? int'($urandom_range(30, 60)) : int'($urandom_range(0, 10));
         for (int i = 0; i < n; i++) prods[i] = 10'($urandom);
         neuron(n, -1, int'($urandom_range(0, 3)), 1'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/fc_accumulator.md
Name: fc_accumulator

Overview:
- Stage directly downstream of the FC signed multiplier.
- Consumes one signed product per accepted beat.
- Sign-extends each product and adds it into a saturating accumulator; after a programmed number of products it presents the neuron pre-activation sum with a valid/ready handshake.
- One instance serves one FC neuron lane.

Parameters:
- N, 5, multiplier operand width; the product is 2N bits signed.
- ACC_W, 16, accumulator/result width, signed; must be ≥ 2N.
- CNT_W, 8, width of the product-count field; max terms per neuron is 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a new neuron; sampled only in IDLE.
- numInputs  in  CNT_W  number of products to accumulate; latched on accepted start.
- prodValid  in  1  mulResult carries a valid product.
- mulResult  in  2N  signed product from the multiplier.
- prodReady  out  1  accumulator accepts a product this cycle.
- accResult  out  ACC_W  signed accumulated sum.
- accValid  out  1  accResult is final.
- outReady  in  1  downstream consumes accResult.
- accSat  out  1  sticky flag: saturation occurred during this neuron.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-accumulation):
  - state=IDLE
  - acc=0, count=0, numLatched=0
  - prodReady=0, accValid=0, accSat=0, busy=0
  - accResult=0
- Beat accepted ⇔ prodValid && prodReady. All updates happen on the rising clk edge.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - prodReady=0, accValid=0.
  - On start: latch numInputs, clear acc, count and accSat.
  - If numInputs≠0, go to ACCUM.
  - If numInputs==0, go directly to DONE with accResult=0.
- ACCUM:
  - prodReady=1.
  - On an accepted beat: acc <= sat(acc + sext(mulResult)); count++.
  - When the accepted beat has count==numLatched-1, go to DONE next edge.
  - prodValid low means a stall: no change.
  - start is ignored.
- DONE:
  - accValid=1, prodReady=0.
  - accResult=acc, held stable until handshake.
  - On outReady, go to IDLE; accValid drops next cycle.
  - start asserted in the same cycle as outReady is ignored; the upstream must re-assert it in IDLE.
- Latency:
  - accValid rises on the first edge after the last beat is accepted.
  - A full neuron takes numInputs+2 cycles minimum (start, numInputs beats, one DONE cycle with outReady=1).
- Arithmetic:
  - Product is sign-extended from 2N to ACC_W+1 bits; the sum is computed in ACC_W+1 bits.
  - Result above 2^(ACC_W-1)-1 clamps to MAX; result below -2^(ACC_W-1) clamps to MIN.
  - Any clamp sets accSat, which stays set until the next start.
  - Saturation is applied per beat: a later opposite-sign product moves off the rail from the clamped value.
- accResult is a registered output; there is no combinational path from mulResult to accResult.
- prodReady depends only on state.

Decomposition:
- Shared package fc_pkg holds:
  - the state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2)
  - functions/constants for signed MAX/MIN at a given width.
- One sub-module: fc_sat_adder, a combinational signed saturating adder with ACC_W/2N params, outputs sum and satHit. Instantiated once.
- The FSM, counter and registers stay in fc_accumulator.

Test Plan:
- Basic sum (N=5, ACC_W=16):
  - Stimulus: start with numInputs=4; products 15, -16, 100, -240, prodValid held high.
  - Expected: accValid one cycle after the 4th beat, accResult=-141, accSat=0.
- Stall/backpressure:
  - Stimulus: numInputs=3; products 10, 20, 30 with prodValid low for 2 cycles between beats; outReady held low 5 cycles in DONE.
  - Expected: accResult=60 held stable all 5 cycles; accValid drops the cycle after outReady=1.
- Saturation (ACC_W=12):
  - Stimulus: 8 products of +256 (-16 × -16), then a second neuron of 2 products: -240, -240.
  - Expected: first result 2047 with accSat=1; second result -480 with accSat=0.
- Zero count:
  - Stimulus: start with numInputs=0.
  - Expected: DONE next cycle, accResult=0, prodReady never asserted.
- Reset mid-accumulation:
  - Stimulus: after 2 of 5 beats, pulse rst_n low asynchronously (mid-cycle).
  - Expected: all outputs 0 immediately; a following neuron of products 1, 2, 3 yields 6.
- Back-to-back neurons:
  - Stimulus: start asserted in the same cycle as the outReady handshake.
  - Expected: that start is ignored; a start re-asserted in IDLE runs a new neuron from acc=0.
